// File: rtl/dpcm_frame_decoder.sv
// Predictive (DPCM) pixel decoder: rebuilds 3-channel pixels from per-pixel residuals
// using a per-frame predictor (avg/left/up/none), a one-line "up" buffer and optional saturation.
module dpcm_frame_decoder #(
    parameter int IMG_W = 800,
    parameter int IMG_H = 600,
    parameter int CW    = 8,
    parameter int RB    = 5,
    parameter int GB    = 6,
    parameter int BB    = 5,
    parameter int SAT   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_mode,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [RB+GB+BB-1:0]   i_data,
    input  logic                  i_sof,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [3*CW-1:0]       o_data,
    output logic                  o_sof,
    output logic                  o_eol
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
    localparam logic [CW-1:0]    MID      = {1'b0, {(CW-1){1'b1}}};

    localparam logic [1:0] MODE_AVG  = 2'd0;
    localparam logic [1:0] MODE_LEFT = 2'd1;
    localparam logic [1:0] MODE_UP   = 2'd2;

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [3*CW-1:0]  left_pix;
    logic [1:0]       mode_lat;
    logic [3*CW-1:0]  linebuf [IMG_W];

    logic [ROW_W-1:0] eff_row;
    logic [COL_W-1:0] eff_col;
    logic             first_pix;
    logic [1:0]       mode_eff;
    logic [3*CW-1:0]  up_pix;
    logic [3*CW-1:0]  dec_pix;
    logic             accept;

    // i_sof overrides the counters so the pixel is always decoded as (0,0)
    assign eff_row   = i_sof ? '0 : row;
    assign eff_col   = i_sof ? '0 : col;
    assign first_pix = (eff_row == '0) && (eff_col == '0);
    assign mode_eff  = first_pix ? i_mode : mode_lat;
    assign up_pix    = linebuf[eff_col];
    assign o_ready   = !o_valid || i_ready;
    assign accept    = i_valid && o_ready;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        localparam int RX  = (c == 0) ? RB : (c == 1) ? GB : BB;
        localparam int LSB = (c == 0) ? GB + BB : (c == 1) ? BB : 0;
        localparam int SH  = CW - RX;
        localparam int HI  = CW * (3 - c) - 1;

        logic [RX-1:0] res;
        logic [CW-1:0] l_v;
        logic [CW-1:0] u_v;
        logic [CW:0]   sum_lu;
        logic [CW-1:0] pred;

        assign res = i_data[LSB +: RX];

        always_comb begin
            l_v    = (eff_col == '0) ? MID : left_pix[HI -: CW];
            u_v    = (eff_row == '0) ? MID : up_pix[HI -: CW];
            sum_lu = {1'b0, l_v} + {1'b0, u_v};
            case (mode_eff)
                MODE_AVG:  pred = CW'(sum_lu >> 1);
                MODE_LEFT: pred = l_v;
                MODE_UP:   pred = u_v;
                default:   pred = MID;
            endcase
        end

        if (SAT == 0) begin : g_mod
            logic [CW-1:0] d_u;
            assign d_u = CW'(res) << SH;
            assign dec_pix[HI -: CW] = pred + d_u;
        end else begin : g_sat
            // Two extra bits hold the sign and the carry, so one add covers both clamp directions
            logic [CW+1:0] d_s;
            logic [CW+1:0] sum_s;
            assign d_s   = {{(CW+2-RX){res[RX-1]}}, res} << SH;
            assign sum_s = {2'b00, pred} + d_s;
            assign dec_pix[HI -: CW] = sum_s[CW+1] ? '0 :
                                       sum_s[CW]   ? '1 : sum_s[CW-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row      <= '0;
            col      <= '0;
            left_pix <= '0;
            mode_lat <= MODE_AVG;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_sof    <= 1'b0;
            o_eol    <= 1'b0;
        end else if (accept) begin
            left_pix <= dec_pix;
            o_data   <= dec_pix;
            o_valid  <= 1'b1;
            o_sof    <= first_pix;
            o_eol    <= (eff_col == LAST_COL);
            if (first_pix) begin
                mode_lat <= i_mode;
            end
            if (eff_col == LAST_COL) begin
                col <= '0;
                row <= (eff_row == LAST_ROW) ? '0 : eff_row + 1'b1;
            end else begin
                col <= eff_col + 1'b1;
                row <= eff_row;
            end
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

    // Read of linebuf[col] above sees the old row; the write lands at the clock edge
    always_ff @(posedge i_clk) begin
        if (accept && !i_rst) begin
            linebuf[eff_col] <= dec_pix;
        end
    end

endmodule

// File: tb/tb_dpcm_frame_decoder.sv
// Self-checking bench: two decoders (modulo and saturating) share one random stream and
// are compared against a frame-level reference model kept as 2-D images.
module tb_dpcm_frame_decoder;

    localparam int W = 5;
    localparam int H = 3;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        valid;
    logic [15:0] data;
    logic        sof;
    logic        ready;

    logic        readyA, validA, sofA, eolA;
    logic [23:0] dataA;
    logic        readyB, validB, sofB, eolB;
    logic [23:0] dataB;

    int numCompared   = 0;
    int numMismatched = 0;

    typedef struct {
        logic [23:0] pix;
        bit          sof;
        bit          eol;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    int   img [2][H][W][3];
    int   mRow = 0;
    int   mCol = 0;
    int   mMode = 0;

    dpcm_frame_decoder #(.IMG_W(W), .IMG_H(H), .SAT(0)) dutA (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_valid(valid), .o_ready(readyA),
        .i_data(data), .i_sof(sof), .o_valid(validA), .i_ready(ready),
        .o_data(dataA), .o_sof(sofA), .o_eol(eolA)
    );

    dpcm_frame_decoder #(.IMG_W(W), .IMG_H(H), .SAT(1)) dutB (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_valid(valid), .o_ready(readyB),
        .i_data(data), .i_sof(sof), .o_valid(validB), .i_ready(ready),
        .o_data(dataB), .o_sof(sofB), .o_eol(eolB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decodeChannel(int p, int res, int rx, int sat);
        int scale = 1 << (8 - rx);
        int s;
        int v;
        if (sat == 0) return (p + res * scale) % 256;
        s = (res >= (1 << (rx - 1))) ? res - (1 << rx) : res;
        v = p + s * scale;
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Reference: U is the pixel directly above in the current image, L the one to its left
    task automatic modelAccept(input logic [15:0] d, input bit s, input logic [1:0] m);
        int r = s ? 0 : mRow;
        int c = s ? 0 : mCol;
        int res [3];
        int rx  [3];
        int lv, uv, p, outv;
        exp_t e;
        res[0] = int'(d[15:11]); res[1] = int'(d[10:5]); res[2] = int'(d[4:0]);
        rx[0] = 5; rx[1] = 6; rx[2] = 5;
        if (r == 0 && c == 0) mMode = int'(m);
        for (int sat = 0; sat < 2; sat++) begin
            e.pix = '0;
            for (int ch = 0; ch < 3; ch++) begin
                lv = (c == 0) ? 127 : img[sat][r][c-1][ch];
                uv = (r == 0) ? 127 : img[sat][r-1][c][ch];
                case (mMode)
                    0:       p = (lv + uv) / 2;
                    1:       p = lv;
                    2:       p = uv;
                    default: p = 127;
                endcase
                outv = decodeChannel(p, res[ch], rx[ch], sat);
                img[sat][r][c][ch] = outv;
                e.pix = {e.pix[15:0], 8'(outv)};
            end
            e.sof = (r == 0 && c == 0);
            e.eol = (c == W - 1);
            if (sat == 0) qA.push_back(e);
            else          qB.push_back(e);
        end
        if (c == W - 1) begin
            mCol = 0;
            mRow = (r == H - 1) ? 0 : r + 1;
        end else begin
            mCol = c + 1;
            mRow = r;
        end
    endtask

    // One clock: drive at negedge, score the upcoming edge, return 1 time unit after it
    task automatic applyStimulus(input bit v, input logic [15:0] d, input bit s,
                                 input logic [1:0] m, input bit rdy, input bit r);
        bit expValid;
        bit expReady;
        @(negedge clk);
        valid = v; data = d; sof = s; mode = m; ready = rdy; rst = r;
        #1;
        if (r) begin
            qA.delete();
            qB.delete();
            mRow = 0; mCol = 0; mMode = 0;
        end else begin
            expValid = (qA.size() != 0);
            expReady = !expValid || rdy;
            checkOutput("validA", 32'(validA), 32'(expValid));
            checkOutput("validB", 32'(validB), 32'(expValid));
            checkOutput("readyA", 32'(readyA), 32'(expReady));
            checkOutput("readyB", 32'(readyB), 32'(expReady));
            if (expValid) begin
                checkOutput("dataA", 32'(dataA), 32'(qA[0].pix));
                checkOutput("sofA",  32'(sofA),  32'(qA[0].sof));
                checkOutput("eolA",  32'(eolA),  32'(qA[0].eol));
                checkOutput("dataB", 32'(dataB), 32'(qB[0].pix));
                checkOutput("sofB",  32'(sofB),  32'(qB[0].sof));
                checkOutput("eolB",  32'(eolB),  32'(qB[0].eol));
                if (rdy) begin
                    void'(qA.pop_front());
                    void'(qB.pop_front());
                end
            end
            if (v && expReady) modelAccept(d, s, m);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; data = '0; sof = 1'b0; mode = '0; ready = 1'b1;

        applyStimulus(0, 16'h0, 0, 2'd0, 1, 1);
        applyStimulus(0, 16'h0, 0, 2'd0, 1, 1);
        checkOutput("rst_valid", 32'(validA), 32'd0);
        checkOutput("rst_data",  32'(dataA),  32'd0);
        checkOutput("rst_sof",   32'(sofA),   32'd0);
        checkOutput("rst_eol",   32'(eolA),   32'd0);
        checkOutput("rst_ready", 32'(readyA), 32'd1);

        // First pixel, zero residual, average mode
        applyStimulus(1, 16'h0, 1, 2'd0, 1, 0);
        checkOutput("t1_valid", 32'(validA), 32'd1);
        checkOutput("t1_data",  32'(dataA),  32'h7F7F7F);
        checkOutput("t1_sof",   32'(sofA),   32'd1);

        applyStimulus(1, {5'd1, 6'd1, 5'd1}, 0, 2'd0, 1, 0);
        checkOutput("t2_dataA", 32'(dataA), 32'h878387);
        checkOutput("t2_dataB", 32'(dataB), 32'h878387);
        checkOutput("t2_sof",   32'(sofA),  32'd0);

        // Rest of row 0, row 1 (up path) and a wrap through (0,0)
        for (int i = 0; i < 28; i++)
            applyStimulus(1, 16'($urandom), 0, 2'd1, 1, 0);

        // Downstream stall with a pending input
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 16'($urandom), 0, 2'd0, 0, 0);
            checkOutput("stall_ready", 32'(readyA), 32'd0);
        end
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 16'($urandom), 0, 2'd0, 1, 0);

        // Saturation: mode 3, +120 then -128 on R
        applyStimulus(1, {5'h0F, 6'd0, 5'd0}, 1, 2'd3, 1, 0);
        checkOutput("sat_pos_B", 32'(dataB[23:16]), 32'hF7);
        checkOutput("sat_pos_A", 32'(dataA[23:16]), 32'hF7);
        applyStimulus(1, {5'h10, 6'd0, 5'd0}, 0, 2'd0, 1, 0);
        checkOutput("sat_neg_B", 32'(dataB[23:16]), 32'h00);
        checkOutput("sat_neg_A", 32'(dataA[23:16]), 32'hFF);
        checkOutput("sat_neg_G", 32'(dataB[15:8]),  32'h7F);

        // Reset mid-frame at (1,2), then restart without i_sof
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 16'($urandom), 0, 2'd0, 1, 0);
        applyStimulus(0, 16'h0, 0, 2'd0, 1, 1);
        checkOutput("midrst_valid", 32'(validA), 32'd0);
        applyStimulus(1, 16'($urandom), 0, 2'd2, 1, 0);
        checkOutput("midrst_sof", 32'(sofA), 32'd1);

        // Mid-line resync with a new mode
        for (int i = 0; i < 2; i++)
            applyStimulus(1, 16'($urandom), 0, 2'd0, 1, 0);
        applyStimulus(1, 16'($urandom), 1, 2'd1, 1, 0);
        checkOutput("resync_sof", 32'(sofA), 32'd1);

        // Random traffic with bubbles, back-pressure, resyncs and occasional resets
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), 16'($urandom),
                          ($urandom_range(0, 49) == 0), 2'($urandom),
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 149) == 0));
        end
        applyStimulus(0, 16'h0, 0, 2'd0, 1, 0);
        applyStimulus(0, 16'h0, 0, 2'd0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
